unidade_funcional_r_pipe: RTL and testbench

- Parametrised, pipelined successor of the integer R-type functional unit of the Tomasulo datapath.
- Accepts one operation per cycle from the reservation station via a valid/ready handshake, carrying the producing-entry tag.
- Computes the result in stage 1 and delays it through LATENCY register stages.
- Presents result plus tag to the CDB arbiter, holding it until granted.

---
 rtl/ufr_pkg.sv | 18 +
 rtl/ufr_if.sv | 33 +++
 rtl/ufr_alu.sv | 42 ++++
 rtl/unidade_funcional_r_pipe.sv | 95 +++++++++
 tb/tb_unidade_funcional_r_pipe.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ufr_pkg.sv
// Shared definitions for the pipelined R-type functional unit:
// operation encodings, the ADD4/SUB4 immediate and default widths.
package ufr_pkg;

    typedef enum logic [2:0] {
        UFOP_ADD  = 3'b000,
        UFOP_SUB  = 3'b001,
        UFOP_SLT  = 3'b010,
        UFOP_CMP  = 3'b011,
        UFOP_ADD4 = 3'b100,
        UFOP_SUB4 = 3'b101
    } ufop_e;

    localparam int unsigned UFR_IMM4   = 4;
    localparam int          UFR_TAG_W  = 4;
    localparam int          UFR_DATA_W = 16;

endpackage

// File: rtl/ufr_if.sv
// Reservation-station issue port and CDB request port of the functional unit.
// The master side is the RS/CDB arbiter; the slave side is the unit itself.
interface ufr_if
    import ufr_pkg::*;
#(
    parameter int DATA_W = UFR_DATA_W,
    parameter int TAG_W  = UFR_TAG_W
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_A;
    logic [DATA_W-1:0] in_B;
    logic [2:0]        in_Ufop;
    logic [TAG_W-1:0]  in_tag;

    logic              out_valid;
    logic [DATA_W-1:0] out_Q;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;
    logic              cdb_grant;

    modport master (
        output in_valid, in_A, in_B, in_Ufop, in_tag, cdb_grant,
        input  in_ready, out_valid, out_Q, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_A, in_B, in_Ufop, in_tag, cdb_grant,
        output in_ready, out_valid, out_Q, out_tag, out_err
    );

endinterface

// File: rtl/ufr_alu.sv
// Combinational result/err computation of the R-type unit; all results
// wrap modulo 2^DATA_W, SLT signedness chosen by SLT_SIGNED.
module ufr_alu
    import ufr_pkg::*;
#(
    parameter int DATA_W     = UFR_DATA_W,
    parameter int SLT_SIGNED = 0
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        ufop,
    output logic [DATA_W-1:0] q,
    output logic              err
);

    localparam logic [DATA_W-1:0] IMM4 = DATA_W'(UFR_IMM4);

    logic less;

    generate
        if (SLT_SIGNED != 0) begin : g_slt_signed
            assign less = $signed(a) < $signed(b);
        end else begin : g_slt_unsigned
            assign less = a < b;
        end
    endgenerate

    always_comb begin
        q   = '0;
        err = 1'b0;
        case (ufop)
            UFOP_ADD:  q = a + b;
            UFOP_SUB:  q = a - b;
            UFOP_SLT:  q = DATA_W'(less);
            UFOP_CMP:  q = DATA_W'(a == b);
            UFOP_ADD4: q = b + IMM4;
            UFOP_SUB4: q = b - IMM4;
            default:   err = 1'b1;
        endcase
    end

endmodule

// File: rtl/unidade_funcional_r_pipe.sv
// Pipelined R-type functional unit: result computed into stage 1, then
// carried through LATENCY (1..8) stages and held for the CDB until granted.
// Optional macro UFR_FLUSH_EN adds a flush input that drops in-flight ops.
module unidade_funcional_r_pipe
    import ufr_pkg::*;
#(
    parameter int DATA_W     = UFR_DATA_W,
    parameter int TAG_W      = UFR_TAG_W,
    parameter int LATENCY    = 2,
    parameter int SLT_SIGNED = 0
) (
    input  logic  clk,
    input  logic  rst,
`ifdef UFR_FLUSH_EN
    input  logic  flush,
`endif
    ufr_if.slave  bus,
    output logic  busy
);

    logic [LATENCY-1:0] stage_valid;
    logic [DATA_W-1:0]  stage_q   [LATENCY];
    logic [TAG_W-1:0]   stage_tag [LATENCY];
    logic [LATENCY-1:0] stage_err;

    logic [DATA_W-1:0]  alu_q;
    logic               alu_err;
    logic               stall;
    logic               accept;
    logic               flush_now;

`ifdef UFR_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    ufr_alu #(
        .DATA_W     (DATA_W),
        .SLT_SIGNED (SLT_SIGNED)
    ) u_alu (
        .a    (bus.in_A),
        .b    (bus.in_B),
        .ufop (bus.in_Ufop),
        .q    (alu_q),
        .err  (alu_err)
    );

    // A result waiting for the CDB freezes the whole pipe, bubbles included.
    assign stall        = stage_valid[LATENCY-1] && !bus.cdb_grant;
    assign bus.in_ready = !stall && !flush_now;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid <= '0;
        end else if (flush_now) begin
            stage_valid <= '0;
        end else if (!stall) begin
            stage_valid[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                stage_valid[i] <= stage_valid[i-1];
            end
        end
    end

    // Data registers are left untouched by a flush; only validity is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_err <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i]   <= '0;
                stage_tag[i] <= '0;
            end
        end else if (!stall && !flush_now) begin
            if (accept) begin
                stage_q[0]   <= alu_q;
                stage_tag[0] <= bus.in_tag;
                stage_err[0] <= alu_err;
            end
            for (int i = 1; i < LATENCY; i++) begin
                stage_q[i]   <= stage_q[i-1];
                stage_tag[i] <= stage_tag[i-1];
                stage_err[i] <= stage_err[i-1];
            end
        end
    end

    assign bus.out_valid = stage_valid[LATENCY-1];
    assign bus.out_Q     = stage_q[LATENCY-1];
    assign bus.out_tag   = stage_tag[LATENCY-1];
    assign bus.out_err   = stage_err[LATENCY-1];
    assign busy          = |stage_valid;

endmodule

// File: tb/tb_unidade_funcional_r_pipe.sv
// Self-checking bench: a queue-based reference model with per-op countdowns
// is compared against the DUT every cycle, plus directed literal checks.
module tb_unidade_funcional_r_pipe;

    localparam int DATA_W     = 16;
    localparam int TAG_W      = 4;
    localparam int LATENCY    = 2;
    localparam int SLT_SIGNED = 0;

    typedef struct {
        logic [DATA_W-1:0] q;
        logic [TAG_W-1:0]  tag;
        logic              err;
        int                wait_n;
    } ent_t;

    typedef struct {
        logic [DATA_W-1:0] q;
        logic [TAG_W-1:0]  tag;
        logic              err;
        int                cyc;
    } done_t;

    logic clk;
    logic rst;
    logic busy;
    logic flush_sig;
    int   checks;
    int   errors;
    int   cyc;
    ent_t  mq[$];
    done_t done_q[$];

    ufr_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    unidade_funcional_r_pipe #(
        .DATA_W     (DATA_W),
        .TAG_W      (TAG_W),
        .LATENCY    (LATENCY),
        .SLT_SIGNED (SLT_SIGNED)
    ) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef UFR_FLUSH_EN
        .flush (flush_sig),
`endif
        .bus   (bus.slave),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result from the operation definitions, using plain integer math.
    function automatic ent_t model_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                      input logic [2:0] op, input logic [TAG_W-1:0] tag);
        ent_t e;
        longint m  = longint'(1) << DATA_W;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = (SLT_SIGNED != 0 && ua >= m / 2) ? ua - m : ua;
        longint sb = (SLT_SIGNED != 0 && ub >= m / 2) ? ub - m : ub;
        longint r  = 0;
        e.err = 1'b0;
        case (op)
            3'd0:    r = (ua + ub) % m;
            3'd1:    r = (ua + m - ub) % m;
            3'd2:    r = (sa < sb) ? 1 : 0;
            3'd3:    r = (ua == ub) ? 1 : 0;
            3'd4:    r = (ub + 4) % m;
            3'd5:    r = (ub + m - 4) % m;
            default: begin r = 0; e.err = 1'b1; end
        endcase
        e.q      = DATA_W'(r);
        e.tag    = tag;
        e.wait_n = LATENCY - 1;
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin : model_update
        ent_t e;
        logic front;
        if (rst) begin
            mq.delete();
        end else begin
            front = 1'b0;
            if (mq.size() > 0) front = (mq[0].wait_n == 0);
            if (flush_sig) begin
                mq.delete();
            end else if (!(front && !bus.cdb_grant)) begin
                if (front) void'(mq.pop_front());
                foreach (mq[i]) if (mq[i].wait_n > 0) mq[i].wait_n = mq[i].wait_n - 1;
                if (bus.in_valid) begin
                    e = model_op(bus.in_A, bus.in_B, bus.in_Ufop, bus.in_tag);
                    mq.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic exp_valid;
        logic exp_ready;
        exp_valid = 1'b0;
        if (mq.size() > 0) exp_valid = (mq[0].wait_n == 0);
        exp_ready = !(exp_valid && !bus.cdb_grant) && !flush_sig;
        check_output("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        check_output("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        check_output("busy", 32'(busy), 32'(mq.size() > 0));
        if (exp_valid) begin
            check_output("out_Q", 32'(bus.out_Q), 32'(mq[0].q));
            check_output("out_tag", 32'(bus.out_tag), 32'(mq[0].tag));
            check_output("out_err", 32'(bus.out_err), 32'(mq[0].err));
        end
    end

    always @(negedge clk) begin
        done_t d;
        if (!rst && bus.out_valid && bus.cdb_grant) begin
            d.q   = bus.out_Q;
            d.tag = bus.out_tag;
            d.err = bus.out_err;
            d.cyc = cyc;
            done_q.push_back(d);
        end
    end

    // Offers one op from posedge+1 timing and returns once it is accepted.
    task automatic apply_stimulus(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                  input logic [2:0] op, input logic [TAG_W-1:0] tag);
        int   n;
        logic rdy;
        n = 0;
        rdy = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_A     = a;
        bus.in_B     = b;
        bus.in_Ufop  = op;
        bus.in_tag   = tag;
        while (!rdy && n < 50) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout actual=0 required=1 tag=%0d", tag);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int k;
        k = 0;
        while (done_q.size() < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_output("drain_count", 32'(done_q.size()), 32'(n));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int n;
        checks = 0;
        errors = 0;
        cyc = 0;
        rst = 1'b1;
        flush_sig = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_A = '0;
        bus.in_B = '0;
        bus.in_Ufop = '0;
        bus.in_tag = '0;
        bus.cdb_grant = 1'b1;

        repeat (2) begin
            @(negedge clk);
            check_output("rst_out_valid", 32'(bus.out_valid), 0);
            check_output("rst_busy", 32'(busy), 0);
            check_output("rst_in_ready", 32'(bus.in_ready), 1);
            check_output("rst_out_Q", 32'(bus.out_Q), 0);
            check_output("rst_out_tag", 32'(bus.out_tag), 0);
            check_output("rst_out_err", 32'(bus.out_err), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("rel_out_valid", 32'(bus.out_valid), 0);
        check_output("rel_busy", 32'(busy), 0);
        check_output("rel_in_ready", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1;

        $display("[TB] single ADD latency");
        bus.in_valid = 1'b1;
        bus.in_A = 16'hFFFF;
        bus.in_B = 16'h0002;
        bus.in_Ufop = 3'b000;
        bus.in_tag = 4'd3;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (LATENCY - 1) @(posedge clk);
        @(negedge clk);
        check_output("add_valid", 32'(bus.out_valid), 1);
        check_output("add_Q", 32'(bus.out_Q), 32'h0001);
        check_output("add_tag", 32'(bus.out_tag), 3);
        check_output("add_err", 32'(bus.out_err), 0);
        @(posedge clk);
        #1;
        wait_done(1);

        $display("[TB] back-to-back ops");
        done_q.delete();
        apply_stimulus(16'd5, 16'd7, 3'b001, 4'd1);
        apply_stimulus(16'h8000, 16'h0001, 3'b010, 4'd2);
        apply_stimulus(16'd3, 16'd3, 3'b011, 4'd3);
        apply_stimulus(16'd0, 16'hFFFE, 3'b100, 4'd4);
        apply_stimulus(16'd0, 16'h0002, 3'b101, 4'd5);
        apply_stimulus(16'd9, 16'd9, 3'b111, 4'd6);
        wait_done(6);
        if (done_q.size() == 6) begin
            check_output("b2b_sub", 32'(done_q[0].q), 32'hFFFE);
            check_output("b2b_slt", 32'(done_q[1].q), (SLT_SIGNED != 0) ? 1 : 0);
            check_output("b2b_cmp", 32'(done_q[2].q), 1);
            check_output("b2b_add4", 32'(done_q[3].q), 32'h0002);
            check_output("b2b_sub4", 32'(done_q[4].q), 32'hFFFE);
            check_output("b2b_bad_q", 32'(done_q[5].q), 0);
            check_output("b2b_bad_err", 32'(done_q[5].err), 1);
            check_output("b2b_good_err", 32'(done_q[4].err), 0);
            for (int i = 0; i < 6; i++) begin
                check_output("b2b_tag", 32'(done_q[i].tag), 32'(i + 1));
                check_output("b2b_cycle", 32'(done_q[i].cyc - done_q[0].cyc), 32'(i));
            end
        end

        $display("[TB] CDB stall");
        done_q.delete();
        bus.cdb_grant = 1'b0;
        fork
            begin
                apply_stimulus(16'h1234, 16'h0001, 3'b000, 4'd7);
                apply_stimulus(16'd9, 16'd8, 3'b011, 4'd8);
                apply_stimulus(16'd5, 16'd6, 3'b111, 4'd9);
            end
            begin
                n = 0;
                while (!bus.out_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check_output("stall_ready", 32'(bus.in_ready), 0);
                    check_output("stall_valid", 32'(bus.out_valid), 1);
                    check_output("stall_Q", 32'(bus.out_Q), 32'h1235);
                    check_output("stall_tag", 32'(bus.out_tag), 7);
                end
                @(posedge clk);
                #1;
                bus.cdb_grant = 1'b1;
            end
        join
        wait_done(3);
        if (done_q.size() == 3) begin
            check_output("drain_tag0", 32'(done_q[0].tag), 7);
            check_output("drain_tag1", 32'(done_q[1].tag), 8);
            check_output("drain_tag2", 32'(done_q[2].tag), 9);
            check_output("drain_q0", 32'(done_q[0].q), 32'h1235);
            check_output("drain_q1", 32'(done_q[1].q), 0);
            check_output("drain_q2", 32'(done_q[2].q), 0);
            check_output("drain_err2", 32'(done_q[2].err), 1);
        end

        $display("[TB] reset with ops in flight");
        apply_stimulus(16'd1, 16'd1, 3'b000, 4'd10);
        apply_stimulus(16'd2, 16'd2, 3'b000, 4'd11);
        rst = 1'b1;
        base = done_q.size();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 2 * LATENCY + 4; i++) begin
            @(negedge clk);
            check_output("rst_mid_valid", 32'(bus.out_valid), 0);
            check_output("rst_mid_busy", 32'(busy), 0);
        end
        check_output("rst_mid_done", 32'(done_q.size()), 32'(base));
        @(posedge clk);
        #1;

`ifdef UFR_FLUSH_EN
        $display("[TB] flush");
        base = done_q.size();
        apply_stimulus(16'd4, 16'd4, 3'b000, 4'd12);
        bus.in_valid = 1'b1;
        bus.in_tag = 4'd14;
        flush_sig = 1'b1;
        @(negedge clk);
        check_output("flush_ready", 32'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        flush_sig = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < LATENCY + 2; i++) begin
            @(negedge clk);
            check_output("flush_valid", 32'(bus.out_valid), 0);
            check_output("flush_busy", 32'(busy), 0);
        end
        check_output("flush_done", 32'(done_q.size()), 32'(base));
        @(posedge clk);
        #1;
`endif

        $display("[TB] random traffic");
        for (int i = 0; i < 2000; i++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.cdb_grant = ($urandom_range(0, 9) < 7);
            bus.in_A      = DATA_W'($urandom);
            bus.in_B      = DATA_W'($urandom);
            bus.in_Ufop   = 3'($urandom_range(0, 7));
            bus.in_tag    = TAG_W'($urandom);
`ifdef UFR_FLUSH_EN
            flush_sig     = ($urandom_range(0, 31) == 0);
`endif
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.cdb_grant = 1'b1;
        flush_sig = 1'b0;
        repeat (LATENCY + 4) @(posedge clk);
        @(negedge clk);
        check_output("final_valid", 32'(bus.out_valid), 0);
        check_output("final_busy", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
